// File: rtl/tx_resp_sched_pkg.sv
// Shared types and constants for the UART response scheduler.
package tx_resp_sched_pkg;

  localparam int BYTE_W = 8;
  localparam int ALU_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  typedef enum logic {SRC_RD, SRC_ALU} src_t;

  // Byte 0 is the LSB half of an ALU result, byte 1 the MSB half.
  function automatic logic [BYTE_W-1:0] alu_byte(input logic [ALU_W-1:0] data,
                                                 input logic idx);
    return idx ? data[ALU_W-1:BYTE_W] : data[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/tx_resp_slot.sv
// Single-entry holding slot: captures a result, flags it pending, and reports
// a lost result with a one-cycle drop pulse.
module tx_resp_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic [W-1:0] data,
  input  logic         free,
  output logic         pend,
  output logic [W-1:0] q,
  output logic         drop
);

  logic         pend_reg;
  logic [W-1:0] data_reg;
  logic         drop_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= 1'b0;
      data_reg <= '0;
      drop_reg <= 1'b0;
    end else begin
      // A slot being freed this cycle can accept a new result without loss.
      drop_reg <= vld && pend_reg && !free;
      if (vld && (!pend_reg || free)) begin
        data_reg <= data;
        pend_reg <= 1'b1;
      end else if (free) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign pend = pend_reg;
  assign q    = data_reg;
  assign drop = drop_reg;

endmodule

// File: rtl/tx_resp_sched.sv
// Response scheduler: arbitrates RegFile/ALU results and paces bytes to the UART
// on the synchronised BUSY flag. Define TX_RESP_SCHED_RR_EN for round-robin.
module tx_resp_sched
  import tx_resp_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter int TO_W        = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RD_VLD,
  input  logic [BYTE_W-1:0] RD_DATA,
  input  logic              ALU_VLD,
  input  logic [ALU_W-1:0]  ALU_DATA,
  input  logic              BUSY,
  output logic [BYTE_W-1:0] TX_P_DATA,
  output logic              TX_D_VALID,
  output logic              RD_PEND,
  output logic              ALU_PEND,
  output logic              DROP,
  output logic              TO_ERR
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT);

  state_t            state_reg, state_next;
  src_t              src_reg;
  logic              byte_idx_reg;
  logic [BYTE_W-1:0] tx_data_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  logic [BYTE_W-1:0] rd_q;
  logic [ALU_W-1:0]  alu_q;
  logic              rd_drop, alu_drop;
  logic              any_pend, pick_rd;
  logic              timeout_hit, more_bytes, byte_done, free_any;

  tx_resp_slot #(.W(BYTE_W)) u_rd_slot (
    .clk   (CLK),
    .rst_n (RST),
    .vld   (RD_VLD),
    .data  (RD_DATA),
    .free  (free_any && (src_reg == SRC_RD)),
    .pend  (RD_PEND),
    .q     (rd_q),
    .drop  (rd_drop)
  );

  tx_resp_slot #(.W(ALU_W)) u_alu_slot (
    .clk   (CLK),
    .rst_n (RST),
    .vld   (ALU_VLD),
    .data  (ALU_DATA),
    .free  (free_any && (src_reg == SRC_ALU)),
    .pend  (ALU_PEND),
    .q     (alu_q),
    .drop  (alu_drop)
  );

  assign any_pend    = RD_PEND || ALU_PEND;
  assign timeout_hit = (state_reg == WAIT_ACK) && (to_cnt_reg == TO_LIMIT);
  assign more_bytes  = (src_reg == SRC_ALU) && !byte_idx_reg;
  assign byte_done   = (state_reg == WAIT_DONE) && !BUSY;
  // A timeout abandons whatever bytes of the response are still outstanding.
  assign free_any    = timeout_hit || (byte_done && !more_bytes);

`ifdef TX_RESP_SCHED_RR_EN
  src_t last_src_reg;

  assign pick_rd = RD_PEND && (!ALU_PEND || (last_src_reg == SRC_ALU));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_src_reg <= SRC_ALU;
    end else if ((state_reg == IDLE) && any_pend) begin
      last_src_reg <= pick_rd ? SRC_RD : SRC_ALU;
    end
  end
`else
  assign pick_rd = RD_PEND;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (any_pend) state_next = ISSUE;
      ISSUE:     state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (timeout_hit)  state_next = IDLE;
        else if (BUSY)    state_next = WAIT_DONE;
      end
      WAIT_DONE: if (!BUSY) state_next = more_bytes ? ISSUE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    TX_D_VALID = 1'b0;
    TO_ERR     = 1'b0;
    case (state_reg)
      ISSUE:    TX_D_VALID = 1'b1;
      WAIT_ACK: begin
        TX_D_VALID = !timeout_hit;
        TO_ERR     = timeout_hit;
      end
      default: ;
    endcase
  end

  // Byte register only reloads in IDLE or after BUSY has fallen, so it is
  // stable for the whole time the transmitter is working on it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      src_reg      <= SRC_ALU;
      byte_idx_reg <= 1'b0;
      tx_data_reg  <= '0;
      to_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (any_pend) begin
          src_reg      <= pick_rd ? SRC_RD : SRC_ALU;
          byte_idx_reg <= 1'b0;
          tx_data_reg  <= pick_rd ? rd_q : alu_byte(alu_q, 1'b0);
        end
        ISSUE:    to_cnt_reg <= '0;
        WAIT_ACK: to_cnt_reg <= to_cnt_reg + TO_W'(1);
        WAIT_DONE: if (!BUSY && more_bytes) begin
          byte_idx_reg <= 1'b1;
          tx_data_reg  <= alu_byte(alu_q, 1'b1);
        end
        default: ;
      endcase
    end
  end

  assign TX_P_DATA = tx_data_reg;
  assign DROP      = rd_drop || alu_drop;

endmodule

// File: tb/tb_tx_resp_sched.sv
// Self-checking bench for tx_resp_sched: directed vector table, corner-case
// sequences, then randomized traffic against a transaction-level model.
module tb_tx_resp_sched;

  localparam int TO = 40;
  localparam int N_RAND = 3000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RD_VLD = 1'b0;
  logic [7:0]  RD_DATA = 8'h00;
  logic        ALU_VLD = 1'b0;
  logic [15:0] ALU_DATA = 16'h0000;
  logic        BUSY = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VALID, RD_PEND, ALU_PEND, DROP, TO_ERR;

  int checks = 0;
  int errors = 0;
  int drop_seen = 0;
  int to_seen = 0;

  always #5 CLK = ~CLK;

  tx_resp_sched #(.ACK_TIMEOUT(TO), .TO_W(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RD_VLD     (RD_VLD),
    .RD_DATA    (RD_DATA),
    .ALU_VLD    (ALU_VLD),
    .ALU_DATA   (ALU_DATA),
    .BUSY       (BUSY),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VALID (TX_D_VALID),
    .RD_PEND    (RD_PEND),
    .ALU_PEND   (ALU_PEND),
    .DROP       (DROP),
    .TO_ERR     (TO_ERR)
  );

  always @(posedge CLK) begin
    if (DROP === 1'b1)   drop_seen++;
    if (TO_ERR === 1'b1) to_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {TX_D_VALID, TX_P_DATA, RD_PEND, ALU_PEND, DROP, TO_ERR};
  endfunction

  task automatic wait_valid(input string name);
    int n = 0;
    while (TX_D_VALID !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check({name, " valid"}, {31'd0, TX_D_VALID}, 32'd1);
  endtask

  // Acts as the UART: sees the byte, raises BUSY for 'hold' cycles, then lowers it.
  // Returns at the negedge where BUSY=0 has just been driven.
  task automatic serve_byte(input logic [7:0] exp, input string name, input int hold);
    wait_valid(name);
    check({name, " data"}, {24'd0, TX_P_DATA}, {24'd0, exp});
    $display("byte %s: tx 0x%02h", name, TX_P_DATA);
    BUSY = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        check({name, " valid drop"}, {31'd0, TX_D_VALID}, 32'd0);
        check({name, " data hold"}, {24'd0, TX_P_DATA}, {24'd0, exp});
      end
    end
    BUSY = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic [7:0]  rd_d;
    logic        alu;
    logic [15:0] alu_d;
    int          nb;
    logic [2:0][7:0] b;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  // Random-phase model state
  bit          m_rd_full, m_alu_full, m_drop, m_send, m_src_rd, m_last_alu;
  logic [7:0]  m_rd_val, m_tx;
  logic [15:0] m_alu_val;
  logic [7:0]  m_q[$];
  int          k, d, h;

  initial begin
    int d0, t0;
    bit seen;
    logic [12:0] exp_o;
    bit rv, av, pick;
    bit freed_rd, freed_alu;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 16'h0000, 1, {8'h00, 8'h00, 8'hA5}, 20};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 16'h1234, 2, {8'h00, 8'h12, 8'h34}, 3};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 16'hBEEF, 3, {8'hBE, 8'hEF, 8'h11}, 3};
    vecs[3] = '{1'b1, 8'h5A, 1'b0, 16'h0000, 1, {8'h00, 8'h00, 8'h5A}, 3};
`ifdef TX_RESP_SCHED_RR_EN
    vecs[4] = '{1'b1, 8'h11, 1'b1, 16'hBEEF, 3, {8'h11, 8'hBE, 8'hEF}, 4};
`else
    vecs[4] = '{1'b1, 8'h11, 1'b1, 16'hBEEF, 3, {8'hBE, 8'hEF, 8'h11}, 4};
`endif

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset outputs", {19'd0, outs()}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("post-reset outputs", {19'd0, outs()}, 32'd0);

    // Table-driven responses
    for (int i = 0; i < 5; i++) begin
      d0 = drop_seen;
      RD_VLD = vecs[i].rd;  RD_DATA = vecs[i].rd_d;
      ALU_VLD = vecs[i].alu; ALU_DATA = vecs[i].alu_d;
      @(negedge CLK);
      RD_VLD = 1'b0; ALU_VLD = 1'b0;
      check($sformatf("vec%0d pend", i), {30'd0, RD_PEND, ALU_PEND}, {30'd0, vecs[i].rd, vecs[i].alu});
      check($sformatf("vec%0d early valid", i), {31'd0, TX_D_VALID}, 32'd0);
      @(negedge CLK);
      for (int j = 0; j < vecs[i].nb; j++)
        serve_byte(vecs[i].b[j], $sformatf("vec%0d b%0d", i, j), vecs[i].hold);
      @(negedge CLK);
      check($sformatf("vec%0d pend clear", i), {30'd0, RD_PEND, ALU_PEND}, 32'd0);
      check($sformatf("vec%0d no drop", i), drop_seen - d0, 32'd0);
      $display("vec%0d done: %0d bytes", i, vecs[i].nb);
      repeat (2) @(negedge CLK);
    end

    // Overflow, then a capture in the exact cycle the slot frees
    d0 = drop_seen;
    RD_VLD = 1'b1; RD_DATA = 8'h11;
    @(negedge CLK);
    RD_VLD = 1'b0;
    wait_valid("ovf");
    check("ovf data", {24'd0, TX_P_DATA}, 32'h11);
    BUSY = 1'b1;
    repeat (2) @(negedge CLK);
    RD_VLD = 1'b1; RD_DATA = 8'h22;
    @(negedge CLK);
    RD_VLD = 1'b0;
    check("ovf drop pulse", {31'd0, DROP}, 32'd1);
    check("ovf data stable", {24'd0, TX_P_DATA}, 32'h11);
    @(negedge CLK);
    check("ovf drop single", {31'd0, DROP}, 32'd0);
    BUSY = 1'b0; RD_VLD = 1'b1; RD_DATA = 8'h33;
    @(negedge CLK);
    RD_VLD = 1'b0;
    check("free-cycle capture", {30'd0, DROP, RD_PEND}, 32'd1);
    serve_byte(8'h33, "free-cycle byte", 3);
    @(negedge CLK);
    check("ovf pend clear", {31'd0, RD_PEND}, 32'd0);
    check("ovf drop count", drop_seen - d0, 32'd1);
    $display("overflow sequence done");

    // ACK timeout on the ALU LSB
    t0 = to_seen;
    ALU_VLD = 1'b1; ALU_DATA = 16'hCAFE;
    @(negedge CLK);
    ALU_VLD = 1'b0;
    wait_valid("timeout");
    repeat (TO) @(negedge CLK);
    check("timeout early", {30'd0, TX_D_VALID, TO_ERR}, 32'd2);
    @(negedge CLK);
    check("timeout pulse", {30'd0, TX_D_VALID, TO_ERR}, 32'd1);
    check("timeout lsb", {24'd0, TX_P_DATA}, 32'hFE);
    @(negedge CLK);
    check("timeout after", {30'd0, TO_ERR, ALU_PEND}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (TX_D_VALID === 1'b1) seen = 1'b1;
    end
    check("timeout msb never", {31'd0, seen}, 32'd0);
    check("timeout count", to_seen - t0, 32'd1);
    $display("timeout sequence done");

    // Reset during WAIT_DONE of ALU byte 0
    d0 = drop_seen; t0 = to_seen;
    ALU_VLD = 1'b1; ALU_DATA = 16'h1234;
    @(negedge CLK);
    ALU_VLD = 1'b0;
    wait_valid("rst");
    BUSY = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1 check("rst async outputs", {19'd0, outs()}, 32'd0);
    @(negedge CLK);
    RST = 1'b1; BUSY = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (TX_D_VALID !== 1'b0 || RD_PEND !== 1'b0 || ALU_PEND !== 1'b0) seen = 1'b1;
    end
    check("rst idle after release", {31'd0, seen}, 32'd0);
    check("rst no drop/to", (drop_seen - d0) + (to_seen - t0), 32'd0);
    $display("reset sequence done");

    // Randomized traffic against a transaction-level model
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    m_rd_full = 0; m_alu_full = 0; m_drop = 0; m_send = 0; m_src_rd = 0;
    m_last_alu = 1; m_rd_val = 0; m_alu_val = 0; m_tx = 0; k = 0; d = 0; h = 0;
    m_q.delete();
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge CLK);
      exp_o = {m_send && (k <= d + 1), m_tx, m_rd_full, m_alu_full, m_drop, 1'b0};
      checks++;
      if (outs() !== exp_o) begin
        errors++;
        if (errors < 20)
          $display("FAIL rand cycle %0d: got 0x%04h required 0x%04h", c, outs(), exp_o);
      end
      rv = ($urandom_range(0, 99) < 6);
      av = ($urandom_range(0, 99) < 6);
      RD_VLD = rv;  RD_DATA = 8'($urandom);
      ALU_VLD = av; ALU_DATA = 16'($urandom);
      BUSY = m_send && (k >= d + 1) && (k <= d + h);

      // Advance the model across the coming clock edge
      freed_rd = 0; freed_alu = 0;
      if (!m_send) begin
        if (m_rd_full || m_alu_full) begin
`ifdef TX_RESP_SCHED_RR_EN
          pick = m_rd_full && (!m_alu_full || m_last_alu);
`else
          pick = m_rd_full;
`endif
          m_q.delete();
          if (pick) m_q.push_back(m_rd_val);
          else begin
            m_q.push_back(m_alu_val[7:0]);
            m_q.push_back(m_alu_val[15:8]);
          end
          $display("rand grant %s at cycle %0d", pick ? "RD" : "ALU", c);
          m_tx = m_q.pop_front();
          m_send = 1; m_src_rd = pick; m_last_alu = !pick;
          k = 0; d = $urandom_range(0, 4); h = $urandom_range(1, 4);
        end
      end else if (k == d + h + 1) begin
        if (m_q.size() > 0) begin
          m_tx = m_q.pop_front();
          k = 0; d = $urandom_range(0, 4); h = $urandom_range(1, 4);
        end else begin
          m_send = 0;
          if (m_src_rd) freed_rd = 1; else freed_alu = 1;
        end
      end else begin
        k++;
      end
      m_drop = 0;
      if (rv) begin
        if (!m_rd_full || freed_rd) begin m_rd_val = RD_DATA; m_rd_full = 1; end
        else m_drop = 1;
      end else if (freed_rd) m_rd_full = 0;
      if (av) begin
        if (!m_alu_full || freed_alu) begin m_alu_val = ALU_DATA; m_alu_full = 1; end
        else m_drop = 1;
      end else if (freed_alu) m_alu_full = 0;
    end
    RD_VLD = 1'b0; ALU_VLD = 1'b0; BUSY = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_resp_sched.md
# tx_resp_sched

Response scheduler between the REF_CLK-domain result sources and the UART transmitter. It captures RegFile read data (8 bit) and ALU results (16 bit) into one holding slot per source, and arbitrates between pending slots. It serialises the granted response into bytes and drives the TX data/valid pair toward the TX-domain data synchroniser, pacing each byte on the synchronised UART busy flag.

## Interface
Parameters:
- ACK_TIMEOUT, 1023: REF_CLK cycles allowed for BUSY to rise after a byte is issued.
- TO_W, 10: width of the timeout counter. It must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-low reset.
- RD_VLD  in  1  single-cycle RegFile read-data valid.
- RD_DATA  in  8  RegFile read data, sampled when RD_VLD=1.
- ALU_VLD  in  1  single-cycle ALU result valid.
- ALU_DATA  in  16  ALU result, sampled when ALU_VLD=1.
- BUSY  in  1  UART TX busy, already synchronised to CLK.
- TX_P_DATA  out  8  byte presented to the TX data synchroniser.
- TX_D_VALID  out  1  byte-valid level.
- RD_PEND  out  1  RegFile slot full.
- ALU_PEND  out  1  ALU slot full.
- DROP  out  1  one-cycle pulse when a response is lost because its slot was full.
- TO_ERR  out  1  one-cycle pulse on ACK timeout.

## Operation
- Reset values: all outputs 0, slots empty, FSM in IDLE, round-robin pointer set to "ALU last granted".
- **Slot capture:**
  - VLD=1 with the slot empty: data is registered and PEND=1 from the next cycle.
  - VLD=1 with the slot full: the new data is discarded and DROP pulses on the next cycle.
  - VLD=1 in the same cycle the slot is freed (last byte completes): the new data is captured and DROP stays 0.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- **IDLE:**
  - With any PEND=1, grant one source and load byte 0.
  - For ALU, byte 0 is ALU_DATA[7:0] and byte 1 is ALU_DATA[15:8]. RegFile has a single byte.
  - Go to ISSUE.
- **ISSUE:** TX_D_VALID=1 and TX_P_DATA=byte. Go to WAIT_ACK the same cycle.
- **WAIT_ACK:**
  - TX_D_VALID is held at 1 until BUSY=1 is observed.
  - On BUSY=1, drop TX_D_VALID and go to WAIT_DONE.
  - If the timeout counter reaches ACK_TIMEOUT first:
    - pulse TO_ERR and drop TX_D_VALID;
    - free the slot, abandoning the remaining bytes;
    - go to IDLE.
- **WAIT_DONE:** on BUSY=0:
  - if more bytes remain, load the next byte and go to ISSUE;
  - otherwise free the slot and go to IDLE.
- TX_P_DATA holds its value from ISSUE until the next ISSUE, never changing while BUSY=1.
- **Arbitration:** fixed priority with RegFile above ALU (see Configuration for round-robin).

## Timing
- RD_VLD at cycle n gives RD_PEND at n+1, grant in IDLE at n+1, and TX_D_VALID=1 at n+2.
- One byte costs at least 4 cycles: ISSUE, ≥1 in WAIT_ACK, ≥1 in WAIT_DONE, then IDLE/ISSUE.
- The timeout counter clears on entry to WAIT_ACK and counts every cycle there. TO_ERR is asserted in the cycle the count equals ACK_TIMEOUT.
- BUSY already high on entry to WAIT_ACK counts as acknowledge in the first WAIT_ACK cycle.
- RST asserted mid-transfer clears everything asynchronously. The partial response is lost and no DROP/TO_ERR is generated.

## Configuration
- TX_RESP_SCHED_RR_EN defined: round-robin arbitration.
  - With both slots pending in IDLE, the source not granted last wins.
  - The pointer updates on each grant.
- Macro undefined: fixed priority, RegFile over ALU. The pointer logic is not built.

## Structure
- Shared package tx_resp_sched_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT_ACK/WAIT_DONE);
  - the source enum (SRC_RD/SRC_ALU);
  - byte-width and ALU-width constants.
- One sub-module, tx_resp_slot, parameterised on data width. It provides capture, PEND, DROP and free, and is instantiated twice.

## Test plan
- **RegFile single byte:** RD_VLD with RD_DATA=0xA5, BUSY pulsed high for 20 cycles after valid.
  - TX_P_DATA=0xA5 and TX_D_VALID high until BUSY rises.
  - RD_PEND clears when BUSY falls. No DROP.
- **ALU two bytes:** ALU_VLD with ALU_DATA=0x1234.
  - Byte sequence is 0x34 then 0x12, each waiting on a separate BUSY high/low pair.
- **Simultaneous requests:** RD 0x11 and ALU 0xBEEF in the same cycle.
  - Fixed priority: 0x11, 0xEF, 0xBE.
  - With TX_RESP_SCHED_RR_EN, repeat after a prior RD grant: ALU bytes go first.
- **Overflow:** second RD_VLD (0x22) while RD slot holds 0x11 mid-transfer.
  - DROP pulses one cycle later and only 0x11 is sent.
  - RD_VLD in the exact cycle 0x11 completes is captured, with no DROP.
- **Timeout:** ALU_VLD with BUSY held at 0.
  - TO_ERR pulses ACK_TIMEOUT cycles after WAIT_ACK entry.
  - ALU_PEND clears, FSM returns to IDLE, and the MSB is never issued.
- **Reset mid-operation:** RST low during WAIT_DONE of an ALU byte 0.
  - All outputs 0 immediately.
  - After release, no byte is sent until a new VLD arrives.
